// File: rtl/mdio_pkg.sv
// Shared types and field widths for the Clause-22 MDIO responder.
package mdio_pkg;

  localparam int PHYAD_W = 5;
  localparam int REGAD_W = 5;
  localparam int DATA_W  = 16;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  typedef enum logic [2:0] {
    PRE,
    ST1,
    OP,
    PHYAD,
    REGAD,
    TA,
    RD_DATA,
    WR_DATA
  } mdio_state_e;

endpackage

// File: rtl/mdio_responder_if.sv
// MDIO pad signals plus the register-file port between responder and register owner.
interface mdio_responder_if;
  import mdio_pkg::*;

  logic               mdc_i;
  logic               mdio_i;
  logic               mdio_o;
  logic               mdio_oe;
  logic [REGAD_W-1:0] reg_addr;
  logic [DATA_W-1:0]  reg_wdata;
  logic               reg_we;
  logic               reg_re;
  logic [DATA_W-1:0]  reg_rdata;
  logic               busy;

  modport slave (
    input  mdc_i, mdio_i, reg_rdata,
    output mdio_o, mdio_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
  );

  modport master (
    output mdc_i, mdio_i, reg_rdata,
    input  mdio_o, mdio_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
  );

endinterface

// File: rtl/mdio_edge_sync.sv
// Synchronises MDC/MDIO into the clk domain and flags synced MDC rising edges.
module mdio_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic mdc_i,
  input  logic mdio_i,
  output logic mdc_rise,
  output logic mdio_s
);

  logic [SYNC_STAGES-1:0] mdc_sync;
  logic [SYNC_STAGES-1:0] mdio_sync;
  logic                   mdc_prev;

  // MDIO idles high on the bus, so its synchroniser resets to 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdc_sync  <= '0;
      mdio_sync <= '1;
      mdc_prev  <= 1'b0;
    end else begin
      mdc_sync  <= {mdc_sync[SYNC_STAGES-2:0], mdc_i};
      mdio_sync <= {mdio_sync[SYNC_STAGES-2:0], mdio_i};
      mdc_prev  <= mdc_sync[SYNC_STAGES-1];
    end
  end

  assign mdc_rise = mdc_sync[SYNC_STAGES-1] & ~mdc_prev;
  assign mdio_s   = mdio_sync[SYNC_STAGES-1];

endmodule

// File: rtl/mdio_responder.sv
// PHY-side Clause-22 MDIO responder with a register-file port.
// Optional: MDIO_PREAMBLE_SUPPRESS_EN accepts a preamble-less frame after a matched one.
module mdio_responder
  import mdio_pkg::*;
#(
  parameter logic [PHYAD_W-1:0] PHY_ADDR    = 5'd0,
  parameter int                 SYNC_STAGES = 2,
  parameter int                 PRE_LEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  mdio_responder_if.slave bus
);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam bit SUPPRESS_EN = 1'b1;
`else
  localparam bit SUPPRESS_EN = 1'b0;
`endif

  localparam int               PRE_W   = $clog2(PRE_LEN + 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRE_LEN);

  logic mdc_rise, mdio_s;

  mdio_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .mdc_i    (bus.mdc_i),
    .mdio_i   (bus.mdio_i),
    .mdc_rise (mdc_rise),
    .mdio_s   (mdio_s)
  );

  mdio_state_e         state_q, state_d;
  logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic                op_hi_q, op_hi_d;
  logic                is_read_q, is_read_d;
  logic                match_q, match_d;
  logic                armed_q, armed_d;
  logic [PHYAD_W-1:0]  phyad_q, phyad_d;
  logic [REGAD_W-2:0]  regad_q, regad_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                mdio_o_q, mdio_o_d, mdio_oe_q, mdio_oe_d;
  logic [REGAD_W-1:0]  reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0]   reg_wdata_q, reg_wdata_d;
  logic                reg_we_q, reg_we_d, reg_re_q, reg_re_d;
  logic                busy_q, busy_d;
  logic                frame_done, frame_abort, drive_rd;

  assign drive_rd = is_read_q & match_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PRE;
      pre_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      op_hi_q     <= 1'b0;
      is_read_q   <= 1'b0;
      match_q     <= 1'b0;
      armed_q     <= 1'b0;
      phyad_q     <= '0;
      regad_q     <= '0;
      shreg_q     <= '0;
      mdio_o_q    <= 1'b1;
      mdio_oe_q   <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      op_hi_q     <= op_hi_d;
      is_read_q   <= is_read_d;
      match_q     <= match_d;
      armed_q     <= armed_d;
      phyad_q     <= phyad_d;
      regad_q     <= regad_d;
      shreg_q     <= shreg_d;
      mdio_o_q    <= mdio_o_d;
      mdio_oe_q   <= mdio_oe_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    op_hi_d     = op_hi_q;
    is_read_d   = is_read_q;
    match_d     = match_q;
    armed_d     = armed_q;
    phyad_d     = phyad_q;
    regad_d     = regad_q;
    shreg_d     = shreg_q;
    mdio_o_d    = mdio_o_q;
    mdio_oe_d   = mdio_oe_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    busy_d      = busy_q;
    frame_done  = 1'b0;
    frame_abort = 1'b0;

    // Read data is captured while reg_re is visible, so reg_addr is already valid for the owner
    if (reg_re_q) shreg_d = bus.reg_rdata;

    if (mdc_rise) begin
      unique case (state_q)
        PRE: begin
          if (mdio_s) begin
            if (pre_cnt_q != PRE_MAX) pre_cnt_d = pre_cnt_q + 1'b1;
          end else if (pre_cnt_q == PRE_MAX || armed_q) begin
            state_d   = ST1;
            busy_d    = 1'b1;
            pre_cnt_d = '0;
            armed_d   = 1'b0;
          end else begin
            pre_cnt_d = '0;
          end
        end
        ST1: begin
          if (mdio_s) begin
            state_d   = OP;
            bit_cnt_d = '0;
          end else begin
            frame_abort = 1'b1;
          end
        end
        OP: begin
          if (bit_cnt_q == 4'd0) begin
            op_hi_d   = mdio_s;
            bit_cnt_d = 4'd1;
          end else if ({op_hi_q, mdio_s} == OP_READ || {op_hi_q, mdio_s} == OP_WRITE) begin
            is_read_d = ({op_hi_q, mdio_s} == OP_READ);
            state_d   = PHYAD;
            bit_cnt_d = '0;
          end else begin
            frame_abort = 1'b1;
          end
        end
        PHYAD: begin
          phyad_d   = {phyad_q[PHYAD_W-2:0], mdio_s};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 4'd4) begin
            state_d   = REGAD;
            bit_cnt_d = '0;
          end
        end
        REGAD: begin
          regad_d   = {regad_q[REGAD_W-3:0], mdio_s};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 4'd4) begin
            reg_addr_d = {regad_q, mdio_s};
            match_d    = (phyad_q == PHY_ADDR);
            reg_re_d   = is_read_q && (phyad_q == PHY_ADDR);
            state_d    = TA;
            bit_cnt_d  = '0;
          end
        end
        TA: begin
          if (bit_cnt_q == 4'd0) begin
            if (drive_rd) begin
              mdio_oe_d = 1'b1;
              mdio_o_d  = 1'b0;
            end
            bit_cnt_d = 4'd1;
          end else begin
            if (drive_rd) begin
              mdio_o_d = shreg_q[DATA_W-1];
              shreg_d  = {shreg_q[DATA_W-2:0], 1'b0};
            end
            state_d   = is_read_q ? RD_DATA : WR_DATA;
            bit_cnt_d = '0;
          end
        end
        RD_DATA: begin
          if (bit_cnt_q != 4'd15) begin
            if (drive_rd) begin
              mdio_o_d = shreg_q[DATA_W-1];
              shreg_d  = {shreg_q[DATA_W-2:0], 1'b0};
            end
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else begin
            mdio_oe_d  = 1'b0;
            mdio_o_d   = 1'b1;
            frame_done = 1'b1;
          end
        end
        WR_DATA: begin
          shreg_d   = {shreg_q[DATA_W-2:0], mdio_s};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 4'd15) begin
            if (match_q) begin
              reg_wdata_d = {shreg_q[DATA_W-2:0], mdio_s};
              reg_we_d    = 1'b1;
            end
            frame_done = 1'b1;
          end
        end
      endcase
    end

    // Every frame end restarts preamble counting; only a completed matched frame may re-arm suppression
    if (frame_done || frame_abort) begin
      state_d   = PRE;
      busy_d    = 1'b0;
      pre_cnt_d = '0;
      bit_cnt_d = '0;
      armed_d   = frame_done && SUPPRESS_EN && match_q;
    end
  end

  assign bus.mdio_o    = mdio_o_q;
  assign bus.mdio_oe   = mdio_oe_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.reg_we    = reg_we_q;
  assign bus.reg_re    = reg_re_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mdio_responder.sv
// Scoreboard bench for mdio_responder: a bench MDIO master drives frames, monitors check strobes and read data.
module tb_mdio_responder;
  import mdio_pkg::*;

  localparam logic [4:0] PHY_ADDR = 5'd0;
  localparam int         PRE_LEN  = 32;
  localparam int         HALF     = 5;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam bit SUPPRESS = 1'b1;
`else
  localparam bit SUPPRESS = 1'b0;
`endif

  typedef struct {
    bit         is_wr;
    logic [4:0] addr;
    logic [15:0] data;
  } strb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mdio_responder_if bus ();

  mdio_responder #(.PHY_ADDR(PHY_ADDR), .SYNC_STAGES(2), .PRE_LEN(PRE_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] mem [32];
  logic [15:0] model_regs [32];
  assign bus.reg_rdata = mem[bus.reg_addr];

  strb_t       exp_strobe [$];
  logic [16:0] exp_rd [$];
  int          n_chk  = 0;
  int          n_fail = 0;
  bit          armed  = 1'b0;
  bit          clean  = 1'b1;
  int          rd_cnt = 0;
  logic [16:0] rd_bits = '0;

  function automatic logic [15:0] init_val(input int i);
    return (i == 2) ? 16'h0141 : 16'((i * 16'h1357) ^ 16'hA5C3);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bench-side sampling of the line on each MDC rising edge while the responder drives it
  initial begin : collector
    bit col_active;
    col_active = 1'b0;
    forever begin
      @(posedge bus.mdc_i);
      if (bus.mdio_oe === 1'b1) begin
        if (!col_active) begin
          rd_cnt  = 0;
          rd_bits = '0;
        end
        rd_bits    = {rd_bits[15:0], bus.mdio_o};
        rd_cnt     = rd_cnt + 1;
        col_active = 1'b1;
      end else begin
        col_active = 1'b0;
      end
    end
  end

  // Monitor: register owner plus scoreboard checks of strobes and completed read bursts
  initial begin : monitor
    logic  oe_prev;
    strb_t e;
    logic [16:0] er;
    oe_prev = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = init_val(i);
    forever begin
      @(negedge clk);
      if (bus.reg_we === 1'b1 || bus.reg_re === 1'b1) begin
        if (bus.reg_we === 1'b1 && bus.reg_re === 1'b1) begin
          chk("we_re_overlap", 32'd1, 32'd0);
        end else if (exp_strobe.size() == 0) begin
          chk("unexpected_strobe_we", {31'd0, bus.reg_we}, {31'd0, ~bus.reg_we});
        end else begin
          e = exp_strobe.pop_front();
          chk("strobe_kind_we", {31'd0, bus.reg_we}, {31'd0, e.is_wr});
          chk("strobe_addr", {27'd0, bus.reg_addr}, {27'd0, e.addr});
          if (e.is_wr) chk("strobe_wdata", {16'd0, bus.reg_wdata}, {16'd0, e.data});
        end
        if (bus.reg_we === 1'b1) mem[bus.reg_addr] = bus.reg_wdata;
      end
      if (oe_prev && bus.mdio_oe !== 1'b1 && rst !== 1'b1) begin
        if (exp_rd.size() == 0) begin
          chk("unexpected_oe_bits", 32'(rd_cnt), 32'd0);
        end else begin
          er = exp_rd.pop_front();
          chk("rd_bit_count", 32'(rd_cnt), 32'd17);
          chk("rd_ta_and_data", {15'd0, rd_bits}, {15'd0, er});
        end
      end
      oe_prev = (bus.mdio_oe === 1'b1);
    end
  end

  task automatic send_bit(input logic b);
    bus.mdio_i = b;
    repeat (HALF) @(posedge clk);
    #1 bus.mdc_i = 1'b1;
    repeat (HALF) @(posedge clk);
    #1 bus.mdc_i = 1'b0;
  endtask

  // Model: a frame is taken if preamble is long enough (or suppression armed) and OP is valid;
  // the register side only sees it when PHYAD matches.
  task automatic run_frame(input int pre, input logic [1:0] op, input logic [4:0] pa,
                           input logic [4:0] ra, input logic [15:0] wd, input int abort_at);
    bit acc, act, hit, is_rd;
    strb_t s;
    acc   = (pre >= PRE_LEN) || armed;
    act   = acc && (op == OP_READ || op == OP_WRITE);
    is_rd = (op == OP_READ);
    hit   = act && (pa == PHY_ADDR);
    if (hit && is_rd) begin
      s.is_wr = 1'b0; s.addr = ra; s.data = 16'h0;
      exp_strobe.push_back(s);
      if (abort_at < 0) exp_rd.push_back({1'b0, model_regs[ra]});
    end
    if (hit && !is_rd) begin
      s.is_wr = 1'b1; s.addr = ra; s.data = wd;
      exp_strobe.push_back(s);
      model_regs[ra] = wd;
    end
    for (int i = 0; i < pre; i++) send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(op[1]);
    send_bit(op[0]);
    chk("busy_after_op", {31'd0, bus.busy}, {31'd0, act});
    for (int i = 4; i >= 0; i--) send_bit(pa[i]);
    for (int i = 4; i >= 0; i--) send_bit(ra[i]);
    if (is_rd) begin
      send_bit(1'b1);
      send_bit(1'b1);
      for (int i = 0; i < 16; i++) begin
        if (abort_at == i) begin
          @(posedge clk);
          #2 rst = 1'b1;
          #1;
          chk("abort_oe", {31'd0, bus.mdio_oe}, 32'd0);
          chk("abort_o", {31'd0, bus.mdio_o}, 32'd1);
          chk("abort_strobes", {30'd0, bus.reg_we, bus.reg_re}, 32'd0);
          chk("abort_busy", {31'd0, bus.busy}, 32'd0);
          repeat (3) @(posedge clk);
          #1 rst = 1'b0;
          armed = 1'b0;
          clean = 1'b1;
          return;
        end
        send_bit(1'b1);
      end
    end else begin
      send_bit(1'b1);
      send_bit(1'b0);
      for (int i = 15; i >= 0; i--) send_bit(wd[i]);
    end
    bus.mdio_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("busy_end", {31'd0, bus.busy}, 32'd0);
    if (act) chk("reg_addr", {27'd0, bus.reg_addr}, {27'd0, ra});
    armed = SUPPRESS && hit;
    clean = act;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, n_chk %0d", n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int          sel, pre;
    logic [1:0]  op;
    logic [4:0]  pa, ra;
    logic [15:0] wd;
    for (int i = 0; i < 32; i++) model_regs[i] = init_val(i);
    bus.mdc_i  = 1'b0;
    bus.mdio_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mdio_o", {31'd0, bus.mdio_o}, 32'd1);
    chk("rst_mdio_oe", {31'd0, bus.mdio_oe}, 32'd0);
    chk("rst_reg_addr", {27'd0, bus.reg_addr}, 32'd0);
    chk("rst_reg_wdata", {16'd0, bus.reg_wdata}, 32'd0);
    chk("rst_strobes", {30'd0, bus.reg_we, bus.reg_re}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    run_frame(32, OP_WRITE, 5'h00, 5'h04, 16'h01E1, -1);
    run_frame(32, OP_READ,  5'h00, 5'h02, 16'h0000, -1);
    run_frame(32, OP_READ,  5'h01, 5'h02, 16'h0000, -1);
    run_frame(31, OP_WRITE, 5'h00, 5'h07, 16'h1234, -1);
    run_frame(32, OP_WRITE, 5'h00, 5'h07, 16'h5678, -1);
    run_frame(32, 2'b11,    5'h00, 5'h03, 16'hBEEF, -1);
    run_frame(32, OP_READ,  5'h00, 5'h04, 16'h0000, 5);
    run_frame(32, OP_WRITE, 5'h00, 5'h09, 16'hA5A5, -1);
    run_frame(0,  OP_WRITE, 5'h00, 5'h0A, 16'h5A5A, -1);
    run_frame(32, OP_READ,  5'h00, 5'h09, 16'h0000, -1);

    for (int n = 0; n < 30; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 4)      op = OP_READ;
      else if (sel < 8) op = OP_WRITE;
      else              op = (sel == 8) ? 2'b11 : 2'b00;
      pa  = ($urandom_range(0, 3) == 0) ? (PHY_ADDR ^ 5'($urandom_range(1, 31))) : PHY_ADDR;
      ra  = 5'($urandom_range(0, 31));
      wd  = 16'($urandom);
      pre = (clean && $urandom_range(0, 3) == 0) ? 0 : 32 + int'($urandom_range(0, 3));
      run_frame(pre, op, pa, ra, wd, -1);
    end

    repeat (10) @(posedge clk);
    chk("strobe_queue_empty", 32'(exp_strobe.size()), 32'd0);
    chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/mdio_responder.md
Name: mdio_responder

Overview:
- PHY-side Clause-22 MDIO management responder; the target end of the MDIO master that drives phy_mdc/phy_mdio in the MAC top level.
- Oversamples MDC/MDIO on the system clock and decodes preamble, ST, OP, PHYAD, REGAD, TA and data.
- Drives turnaround and read data back on MDIO.
- Exposes a simple register-file port so a PHY model, loopback PHY or emulated PHY can own the registers.

Parameters:
- PHY_ADDR, 5'd0, PHY address this responder answers to.
- SYNC_STAGES, 2, synchroniser depth on mdc_i and mdio_i (min 2).
- PRE_LEN, 32, consecutive 1s required as preamble before ST.

Ports:
- clk  in  1  system clock, ≥ 8x MDC frequency.
- rst  in  1  reset. Asynchronous, active-high.
- mdc_i  in  1  MDC from master, asynchronous.
- mdio_i  in  1  MDIO pad input, asynchronous.
- mdio_o  out  1  MDIO output value.
- mdio_oe  out  1  MDIO output enable, 1 = drive.
- reg_addr  out  5  REGAD of the current frame.
- reg_wdata  out  16  write data, valid with reg_we.
- reg_we  out  1  one-clk write strobe.
- reg_re  out  1  one-clk read strobe; reg_rdata is sampled on this cycle.
- reg_rdata  in  16  read data from the register owner.
- busy  out  1  high from ST detect until the frame ends or aborts.

Behaviour:
- Reset values: mdio_o=1, mdio_oe=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, state=PRE, preamble count=0.
- rst asserted mid-frame releases mdio_oe immediately (asynchronous).
- Input conditioning: mdc_i and mdio_i each pass through SYNC_STAGES flops.
- Rising MDC edge ("edge") = synced mdc 0→1. All decode happens on edge; the bit value is synced mdio at that cycle.
- Outputs change only in the clk cycle after an edge (PHY drives after the MDC rising edge).
- PRE state:
  - Count consecutive 1s, saturating at PRE_LEN.
  - A 0 with count==PRE_LEN → ST1, busy=1.
  - A 0 with count<PRE_LEN → count=0, stay in PRE.
- ST1: bit 1 → OP. Bit 0 → PRE, count=0, busy=0.
- OP: shift 2 bits. 10 = read, 01 = write. 00 or 11 → PRE, busy=0, no strobes.
- PHYAD: shift 5 bits MSB first.
- REGAD: shift 5 bits MSB first.
  - On the 5th edge, reg_addr is updated.
  - On the same edge, if read and PHYAD==PHY_ADDR, pulse reg_re one clk and latch reg_rdata into the shift register.
- TA on read with address match:
  - TA1 edge: mdio_oe=1, mdio_o=0 (master samples 0 at TA2).
  - TA2 edge: drive D15.
- RD_DATA:
  - On each of the next 15 edges, shift out D14..D0.
  - On the edge after D0 was sampled: mdio_oe=0, then PRE, busy=0.
- TA on write: 2 edges, TA values are not checked. Then WR_DATA.
- WR_DATA:
  - Shift 16 bits MSB first.
  - On the 16th edge with address match, reg_wdata=data and reg_we pulses one clk.
  - Then PRE, busy=0.
- Address mismatch: still walk the frame to its end with mdio_oe=0 and no strobes, then PRE.
- After every frame the preamble count restarts at 0, so the next frame needs a full preamble.
- No timeout. A stalled MDC holds the state indefinitely; only rst or the frame completing returns the block to PRE.
- reg_re and reg_we are never high together and are never high outside a matched frame.

Optional Feature:
- Macro: MDIO_PREAMBLE_SUPPRESS_EN.
- Defined: after a completed matched frame, the next frame is accepted with zero preamble (ST may immediately follow). Any aborted or mismatched frame re-arms the full preamble requirement.
- Undefined: PRE_LEN ones are always required.

Decomposition:
- Shared package mdio_pkg:
  - state enum (PRE, ST1, OP, PHYAD, REGAD, TA, RD_DATA, WR_DATA).
  - OP codes OP_READ=2'b10, OP_WRITE=2'b01.
  - Field widths (5/5/16).
- One natural sub-module: mdio_edge_sync (synchroniser plus MDC rising-edge detector, outputs mdc_rise and mdio_s).

Test Plan:
- Write, address match: 32 ones, 01, 01, PHYAD=0, REGAD=5'h04, 10, 16'h01E1 → single reg_we with reg_addr=4, reg_wdata=16'h01E1; mdio_oe never 1.
- Read, address match: read REGAD=5'h02 with reg_rdata=16'h0141 → one reg_re; mdio_oe rises after TA1 edge; master samples 0 then 0141 MSB first; oe drops after D0.
- Address mismatch: read frame with PHYAD=5'h01 → no reg_re/reg_we, mdio_oe stays 0, busy falls at frame end.
- Short preamble: 31 ones then 01 → frame ignored; an immediately following full-preamble write is accepted.
- Invalid OP: OP=11 → back to PRE with busy=0; rst asserted during RD_DATA → mdio_oe=0 within the same cycle, all strobes 0.
- With MDIO_PREAMBLE_SUPPRESS_EN: two back-to-back matched writes, the second with no preamble → two reg_we pulses. Without the macro → only the first.
